add_share_arb: RTL and testbench

//  Round-robin arbiter and sequencer sharing one 64-bit CLA adder (add) among NREQ requesters
//  (e.g. PC increment, ALU, address calc). One request is granted per cycle; operands/op are
//  fed to the shared adder and the result is registered into a 1-entry output slot. The result
//  is returned with the requester ID over a valid/ready handshake. Sits between decode/execute

---
 rtl/add_share_arb_pkg.sv | 19 +
 rtl/add.sv | 38 +++
 rtl/add_share_arb_rr_pick.sv | 31 +++
 rtl/add_share_arb.sv | 118 +++++++++++
 tb/tb_add_share_arb.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_arb_pkg.sv
// Shared definitions for the add_share_arb slice: slot FSM encoding, datapath width,
// add/sub op encoding and the registered adder-result record.
package add_share_arb_pkg;

  localparam int W = 64;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
    logic         cout;
  } add_res_t;

endpackage

// File: rtl/add.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups with group generate/propagate chaining.
// Purely combinational; ovf is carry into bit 63 XOR carry out of bit 63.
module add (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf
);

  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 16; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      // Group carry-out from group G/P, independent of the in-group ripple terms.
      c[4*k+4] = (g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]))
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[63:0];
  assign cout = c[64];
  assign ovf  = c[64] ^ c[63];

endmodule

// File: rtl/add_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Returns one-hot grant, its index and whether anything was picked.
module add_share_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin share of one 64-bit adder among NREQ requesters; accept in cycle N -> rsp_valid in N+1.
// One-entry result slot; refilled on the draining cycle, held with req_ready=0 while rsp_ready=0.
// Optional condition-code outputs rsp_zf/rsp_sf under ADD_SHARE_ARB_FLAGS_EN.
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_ovf,
  output logic                 rsp_cout
`ifdef ADD_SHARE_ARB_FLAGS_EN
  ,
  output logic                 rsp_zf,
  output logic                 rsp_sf
`endif
);

  logic [0:0]      state;
  logic [IDW-1:0]  rr_ptr;
  logic            slot_free;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            gany;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic            sub_sel;
  add_res_t        add_res;
  add_res_t        slot_res;
  logic [IDW-1:0]  slot_id;

  assign slot_free = (state == ST_EMPTY) || rsp_ready;

  // No grants while in reset so nothing is handed a ready it cannot complete.
  add_share_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req_valid & {NREQ{slot_free && !rst}}),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign req_ready = gnt;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel   = req_a[i*W +: W];
        b_sel   = req_b[i*W +: W];
        sub_sel = req_sub[i];
      end
    end
  end

  add u_add (
    .a    (a_sel),
    .b    (b_sel ^ {W{sub_sel}}),
    .cin  (sub_sel == OP_SUB),
    .sum  (add_res.sum),
    .cout (add_res.cout),
    .ovf  (add_res.ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      rr_ptr   <= '0;
      slot_id  <= '0;
      slot_res <= '0;
    end else if (gany) begin
      state    <= ST_FULL;
      slot_id  <= gidx;
      slot_res <= add_res;
      rr_ptr   <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end else if ((state == ST_FULL) && rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state == ST_FULL);
  assign rsp_id    = slot_id;
  assign rsp_sum   = slot_res.sum;
  assign rsp_ovf   = slot_res.ovf;
  assign rsp_cout  = slot_res.cout;

`ifdef ADD_SHARE_ARB_FLAGS_EN
  logic zf_q;
  logic sf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
    end else if (gany) begin
      zf_q <= (add_res.sum == '0);
      sf_q <= add_res.sum[W-1];
    end
  end

  assign rsp_zf = zf_q;
  assign rsp_sf = sf_q;
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: a behavioural arbiter/adder model predicts grants and
// queues expected results that are compared when the slot presents them.
module tb_add_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ovf;
  logic              rsp_cout;
`ifdef ADD_SHARE_ARB_FLAGS_EN
  logic              rsp_zf;
  logic              rsp_sf;
`endif

  add_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_cout  (rsp_cout)
`ifdef ADD_SHARE_ARB_FLAGS_EN
    ,
    .rsp_zf    (rsp_zf),
    .rsp_sf    (rsp_sf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] sum;
    logic        ovf;
    logic        cout;
    logic        zf;
    logic        sf;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_full;
  logic [1:0] m_ptr;
  logic       auto_drop;
  int         n_checks;
  int         n_fail;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic sub);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = sub;
    req_valid[i]    = 1'b1;
  endtask

  // Independent reference: two's-complement add with overflow from operand/result signs.
  task automatic push_exp(input int g);
    logic [63:0] a, bb;
    logic [64:0] s;
    logic        sub;
    exp_t        e;
    a    = req_a[g*W +: W];
    sub  = req_sub[g];
    bb   = sub ? ~req_b[g*W +: W] : req_b[g*W +: W];
    s    = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
    e.id   = g[1:0];
    e.sum  = s[63:0];
    e.cout = s[64];
    e.ovf  = (a[63] == bb[63]) && (s[63] != a[63]);
    e.zf   = (s[63:0] == 64'd0);
    e.sf   = s[63];
    exp_q.push_back(e);
  endtask

  task automatic step();
    logic [3:0] eg;
    int         g, j;
    logic       nfull;
    logic [1:0] nptr;
    exp_t       e;
    @(negedge clk);
    if (m_full) begin
      check("rsp_valid", rsp_valid, 1);
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 0, 1);
      end else begin
        e = exp_q[0];
        check("rsp_id", rsp_id, e.id);
        check("rsp_sum", rsp_sum, e.sum);
        check("rsp_ovf", rsp_ovf, e.ovf);
        check("rsp_cout", rsp_cout, e.cout);
`ifdef ADD_SHARE_ARB_FLAGS_EN
        check("rsp_zf", rsp_zf, e.zf);
        check("rsp_sf", rsp_sf, e.sf);
`endif
      end
    end else begin
      check("rsp_valid", rsp_valid, 0);
    end
    eg = '0;
    g  = -1;
    if (!rst && (!m_full || rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (int'(m_ptr) + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", req_ready, eg);
    nfull = m_full;
    nptr  = m_ptr;
    if (m_full && rsp_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      nfull = 1'b0;
    end
    if (g >= 0) begin
      push_exp(g);
      nfull = 1'b1;
      nptr  = 2'((g + 1) % NREQ);
    end
    if (rst) begin
      exp_q.delete();
      nfull = 1'b0;
      nptr  = 2'd0;
    end
    @(posedge clk);
    m_full = nfull;
    m_ptr  = nptr;
    #1;
    if (g >= 0 && auto_drop) req_valid[g] = 1'b0;
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    auto_drop = 1'b1;
    m_full    = 1'b0;
    m_ptr     = 2'd0;
    step();
    step();
    rst = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_ovf", rsp_ovf, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_req_ready", req_ready, 0);

    // Single add, then signed overflow and a subtraction.
    set_req(0, 64'd5, 64'd7, 1'b0);
    step();
    check("t1_sum", rsp_sum, 64'd12);
    check("t1_id", rsp_id, 0);
    set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step();
    check("t2_sum", rsp_sum, 64'h8000_0000_0000_0000);
    check("t2_ovf", rsp_ovf, 1);
    check("t2_cout", rsp_cout, 0);
    set_req(1, 64'd3, 64'd5, 1'b1);
    step();
    check("t2_sub_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_sub_ovf", rsp_ovf, 0);
    check("t2_sub_cout", rsp_cout, 0);
    step();

    // Four continuous requesters from ptr=0: rotation 0,1,2,3,0.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    auto_drop = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'(i * 100), 64'(i), 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("rr_seq", rsp_id, exp_seq[c]);
    end
    req_valid = '0;
    auto_drop = 1'b1;
    step();

    // Back-pressure: hold three cycles, release with req2 pending.
    rsp_ready = 1'b0;
    set_req(0, 64'd1000, 64'd1, 1'b0);
    step();
    set_req(2, 64'd50, 64'd8, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_sum", rsp_sum, 64'd1001);
    end
    check("bp_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    check("bp_next_id", rsp_id, 2);
    check("bp_next_valid", rsp_valid, 1);
    step();

    // Reset while full with req1 pending.
    rsp_ready = 1'b0;
    set_req(3, 64'd11, 64'd22, 1'b0);
    step();
    set_req(1, 64'd40, 64'd2, 1'b0);
    rst = 1'b1;
    step();
    check("rst_full_valid", rsp_valid, 0);
    step();
    check("rst_full_req_ready", req_ready, 0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("rst_then_id", rsp_id, 1);
    check("rst_then_sum", rsp_sum, 64'd42);
    step();

`ifdef ADD_SHARE_ARB_FLAGS_EN
    set_req(0, 64'd9, 64'd9, 1'b1);
    step();
    check("f_zf", rsp_zf, 1);
    check("f_sf", rsp_sf, 0);
    set_req(0, 64'd0, 64'd1, 1'b1);
    step();
    check("f_zf2", rsp_zf, 0);
    check("f_sf2", rsp_sf, 1);
    check("f_cout2", rsp_cout, 0);
    step();
`endif

    // Random traffic with random back-pressure.
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 2 == 0))
          set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom % 2));
      end
      rsp_ready = ($urandom % 4) != 0;
      step();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    req_valid = '0;
    step();
    step();
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
